// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input handshake and program-memory write port
// of the program loader. The loader uses the slave modport; the byte source /
// memory model side uses the master modport.
interface prog_loader_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 6
);
    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [INSTR_WIDTH-1:0] wr_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams a program image into program memory while holding the
// CPU in reset. Stream format: one count byte N (0 = full memory), then N
// instruction words sent MSB-first, each ceil(INSTR_WIDTH/8) bytes.
// Optional build macro LOADER_CHECKSUM_EN adds a trailer byte that must equal
// the XOR of the count and all data bytes; on mismatch the CPU stays held.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start, CPU released
// COUNT    | accept word-count byte, reject oversize loads
// ASSEMBLE | shift in the bytes of one instruction word
// WRITE    | single-cycle program memory write
// CHECK    | accept and compare checksum trailer (LOADER_CHECKSUM_EN only)
// FINISH   | single-cycle done pulse, CPU released
module prog_loader #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 6
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    prog_loader_if.slave  bus,
    output logic          o_cpu_hold,
    output logic          o_done,
    output logic          o_error
);

    localparam int         BPW       = (INSTR_WIDTH + 7) / 8;
    localparam int         NW        = ADDR_WIDTH + 1;
    localparam logic [1:0] BYTE_LAST = 2'(BPW - 1);
    localparam logic [8:0] MAX_WORDS = 9'(1 << ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COUNT    = 3'd1,
        S_ASSEMBLE = 3'd2,
        S_WRITE    = 3'd3,
        S_FINISH   = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHECK    = 3'd5
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   w_in_ready;
    logic                   w_wr_en;
    logic                   w_cpu_hold;
    logic                   w_done;
    logic                   w_accept;

    logic [8:0]             w_cnt_words;
    logic                   w_too_big;
    logic [NW-1:0]          w_n_words;
    logic [INSTR_WIDTH-1:0] w_word;

    logic [1:0]             r_byte_left;
    logic [NW-1:0]          r_words_left;
    logic [INSTR_WIDTH-9:0] r_shreg;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [INSTR_WIDTH-1:0] r_wr_data;
    logic                   r_error;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             r_csum;
    logic                   r_hold_fail;
    logic                   w_csum_ok;

    assign w_csum_ok = (bus.in_data == r_csum);
`endif

    // Count byte 0 encodes a full memory; anything beyond the memory is rejected.
    assign w_cnt_words = (bus.in_data == 8'd0) ? MAX_WORDS : {1'b0, bus.in_data};
    assign w_too_big   = (w_cnt_words > MAX_WORDS);
    assign w_n_words   = NW'(w_cnt_words);

    // The shift register only keeps INSTR_WIDTH-8 bits, so surplus high bits
    // of the first byte of a word fall off the top naturally.
    assign w_word   = {r_shreg, bus.in_data};
    assign w_accept = bus.in_valid & w_in_ready;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_wr_en     = 1'b0;
        w_cpu_hold  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                w_in_ready = 1'b1;
                w_cpu_hold = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = w_too_big ? S_IDLE : S_ASSEMBLE;
                end
            end
            S_ASSEMBLE: begin
                w_in_ready = 1'b1;
                w_cpu_hold = 1'b1;
                if (bus.in_valid && (r_byte_left == 2'd0)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_wr_en    = 1'b1;
                w_cpu_hold = 1'b1;
                if (r_words_left == NW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_nxt = S_CHECK;
`else
                    w_state_nxt = S_FINISH;
`endif
                end else begin
                    w_state_nxt = S_ASSEMBLE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_in_ready = 1'b1;
                w_cpu_hold = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = w_csum_ok ? S_FINISH : S_IDLE;
                end
            end
`endif
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef LOADER_CHECKSUM_EN
        // A failed checksum keeps the CPU parked until a new load or reset.
        if (r_hold_fail) begin
            w_cpu_hold = 1'b1;
        end
`endif
    end

    // Counters, word assembly, write port registers and the error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_left  <= 2'd0;
            r_words_left <= '0;
            r_shreg      <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
            r_hold_fail  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_error   <= 1'b0;
                        r_wr_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_csum      <= 8'd0;
                        r_hold_fail <= 1'b0;
`endif
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        r_words_left <= w_n_words;
                        r_byte_left  <= BYTE_LAST;
                        if (w_too_big) begin
                            r_error <= 1'b1;
                        end
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.in_data;
`endif
                    end
                end
                S_ASSEMBLE: begin
                    if (w_accept) begin
                        r_shreg <= w_word[INSTR_WIDTH-9:0];
                        if (r_byte_left == 2'd0) begin
                            r_wr_data   <= w_word;
                            r_byte_left <= BYTE_LAST;
                        end else begin
                            r_byte_left <= r_byte_left - 2'd1;
                        end
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.in_data;
`endif
                    end
                end
                S_WRITE: begin
                    r_wr_addr    <= r_wr_addr + ADDR_WIDTH'(1);
                    r_words_left <= r_words_left - NW'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept && !w_csum_ok) begin
                        r_error     <= 1'b1;
                        r_hold_fail <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = w_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign o_cpu_hold   = w_cpu_hold;
    assign o_done       = w_done;
    assign o_error      = r_error;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program memory interface: the CPU fetches instruction words, and this block streams them in and writes them into program memory.
- Accepts a byte stream on a valid/ready handshake, assembles instruction words MSB-first, and issues one write per word at consecutive addresses from 0.
- Holds the CPU in reset for the whole load.
- Sits between an external byte source (UART receiver or test host) and the program memory write port.

Parameters:
INSTR_WIDTH, 16, instruction word width in bits (9..32)
ADDR_WIDTH, 6, program memory address width (1..8)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse, begins a load
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte this cycle
wr_en  output  1  program memory write strobe
wr_addr  output  ADDR_WIDTH  program memory write address
wr_data  output  INSTR_WIDTH  program memory write data
cpu_hold  output  1  high while loading; ORed into CPU reset externally
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky load-failure flag; cleared by next start or reset

Behaviour:
- BPW (bytes per word) = ceil(INSTR_WIDTH/8). A byte transfers on a rising edge when in_valid && in_ready.
- Reset (asynchronous assert, synchronous release):
  - state=IDLE.
  - in_ready, wr_en, cpu_hold, done, error = 0.
  - wr_addr=0, wr_data=0, byte and word counters = 0.
- State machine:
  - IDLE: in_ready=0, cpu_hold=0. On start: go to COUNT, error<=0, wr_addr<=0.
  - COUNT: in_ready=1, cpu_hold=1. The accepted byte sets N, the number of words. N=0 means 2^ADDR_WIDTH words. If N > 2^ADDR_WIDTH: error<=1, go to IDLE. Otherwise go to ASSEMBLE.
  - ASSEMBLE: in_ready=1, cpu_hold=1.
    - Shift register: shreg <= {shreg, in_data}.
    - After BPW bytes, go to WRITE.
    - Surplus high bits of the first byte are discarded: wr_data takes the low INSTR_WIDTH bits of the assembled 8*BPW bits.
  - WRITE: exactly one cycle, with in_ready=0, wr_en=1, wr_addr = current word index, and wr_data valid.
    - Next cycle, wr_addr increments.
    - If words written == N, go to CHECK (feature on) or FINISH. Otherwise go to ASSEMBLE.
  - CHECK: only with the optional feature (see below).
  - FINISH: one cycle with done=1 and cpu_hold=0, then IDLE.
- Latency: wr_en asserts the cycle after the last byte of a word is accepted. The minimum load time for N words is 1 + N*(BPW+1) (+1 with CHECK) + 1 cycles.
- wr_addr: holds its last value outside WRITE. It wraps naturally only when N=2^ADDR_WIDTH; the final increment returns it to 0.
- start outside IDLE is ignored.
- in_valid is ignored when in_ready=0. The source may hold in_data/in_valid across stall cycles.
- Reset mid-load: the load is abandoned immediately and cpu_hold drops. Partially written memory is not cleared.
- wr_data and wr_addr are registered outputs. wr_en is registered, never combinational from in_valid.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - After the last word, CHECK takes one trailer byte (in_ready=1).
  - The running XOR of all count and data bytes is compared with the trailer.
  - Match: go to FINISH.
  - Mismatch: error<=1, no done pulse, and cpu_hold stays 1 until the next start or reset, so the CPU does not run corrupt code.
- Undefined: no CHECK state, no trailer byte; error is set only by an oversized N.

Test Plan:
- Load with N=2, bytes 12 34 AB CD, in_valid held high -> wr_en pulses twice: (addr 0, data 0x1234), then (addr 1, data 0xABCD); done one cycle later; cpu_hold high from the cycle after start until the done cycle.
- Same stream with in_valid toggling 1,0,1,0 -> identical writes and data; in_ready never falls during ASSEMBLE; no write while in_valid=0.
- Count byte 0x00 with ADDR_WIDTH=6, 64 words of 0x0000..0x003F -> 64 writes; last wr_addr=63; after FINISH wr_addr=0; done=1.
- ADDR_WIDTH=4 with count byte 0x11 (17) -> error=1, no wr_en, returns to IDLE, cpu_hold=0.
- Reset asserted after the first byte of word 1 -> all outputs go to reset values asynchronously; after release, start plus a full N=1 load (0xBEEF) writes addr 0 = 0xBEEF.
- LOADER_CHECKSUM_EN, N=1, bytes 01 12 34, trailer 0x27 -> done=1. With trailer 0x00 instead -> error=1, no done, cpu_hold stays 1.
